// File: rtl/alu_share_arbiter_if.sv
// Request/response and ALU-side signal bundle for alu_share_arbiter.
// The slave modport is the arbiter's view; master is the client/ALU side.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 32
);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]       req0_op, req1_op;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero;
    logic             busy;
    logic [WIDTH-1:0] alu_input1, alu_input2;
    logic [3:0]       alu_ALUControl;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, busy,
               alu_input1, alu_input2, alu_ALUControl
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
               req0_op, req1_op, rsp0_ready, rsp1_ready, alu_result, alu_zero,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero, busy,
               alu_input1, alu_input2, alu_ALUControl
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin front end sharing one combinational ALU between two clients.
// One operation in flight: accept -> one EXEC cycle -> RESP until consumed.
module alu_share_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic             r_last, r_id;
    logic [WIDTH-1:0] r_a, r_b, r_result;
    logic [3:0]       r_op;
    logic             r_zero;
    logic             w_grant_id, w_accept;

    // On a tie the requester that did not win last time is granted.
    always_comb begin
        w_grant_id = 1'b0;
        if (bus.req0_valid && bus.req1_valid) w_grant_id = ~r_last;
        else if (bus.req1_valid)              w_grant_id = 1'b1;
    end

    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!reset && (bus.req0_valid || bus.req1_valid)) begin
                    w_accept       = 1'b1;
                    bus.req0_ready = ~w_grant_id;
                    bus.req1_ready = w_grant_id;
                    w_next         = S_EXEC;
                end
            end
            S_EXEC: w_next = S_RESP;
            S_RESP: begin
                bus.rsp0_valid = ~r_id;
                bus.rsp1_valid = r_id;
                if (r_id ? bus.rsp1_ready : bus.rsp0_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= 1'b1;
            r_id     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
                r_a    <= w_grant_id ? bus.req1_a  : bus.req0_a;
                r_b    <= w_grant_id ? bus.req1_b  : bus.req0_b;
                r_op   <= w_grant_id ? bus.req1_op : bus.req0_op;
            end
            if (r_state == S_EXEC) begin
                r_result <= bus.alu_result;
                r_zero   <= bus.alu_zero;
            end
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.rsp0_result    = r_result;
    assign bus.rsp1_result    = r_result;
    assign bus.rsp0_zero      = r_zero;
    assign bus.rsp1_zero      = r_zero;
    assign bus.alu_input1     = r_a;
    assign bus.alu_input2     = r_b;
    assign bus.alu_ALUControl = r_op;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: external ALU model, queue-fed requesters,
// transaction-level reference model checked every cycle, plus directed literals.
module tb_alu_share_arbiter;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_BAD = 4'b1111;

    typedef struct { logic [31:0] a; logic [31:0] b; logic [3:0] op; } req_t;
    typedef struct { int id; int cyc; } grant_t;
    typedef struct { int id; logic [31:0] res; logic z; int cyc; } rsp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   n_checks = 0;
    int   n_err    = 0;

    req_t   q0[$], q1[$];
    grant_t glog[$];
    rsp_t   rlog[$];

    alu_share_arbiter_if #(.WIDTH(32)) bus ();

    alu_share_arbiter #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [32:0] alu_ref(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (op)
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), r};
    endfunction

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1 && !v0;
    endfunction

    logic [32:0] w_alu;
    assign w_alu          = alu_ref(bus.alu_ALUControl, bus.alu_input1, bus.alu_input2);
    assign bus.alu_result = w_alu[31:0];
    assign bus.alu_zero   = w_alu[32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;
    initial cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding op, result available one edge after accept.
    logic        m_busy, m_last, m_id, m_age, m_zero;
    logic [31:0] m_a, m_b, m_res;
    logic [3:0]  m_op;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 1'b0; m_last <= 1'b1; m_id <= 1'b0; m_age <= 1'b0;
            m_a <= '0; m_b <= '0; m_op <= '0; m_res <= '0; m_zero <= 1'b0;
        end else if (!m_busy) begin
            if (bus.req0_valid || bus.req1_valid) begin
                m_id   <= pick(bus.req0_valid, bus.req1_valid, m_last);
                m_last <= pick(bus.req0_valid, bus.req1_valid, m_last);
                m_a    <= pick(bus.req0_valid, bus.req1_valid, m_last) ? bus.req1_a  : bus.req0_a;
                m_b    <= pick(bus.req0_valid, bus.req1_valid, m_last) ? bus.req1_b  : bus.req0_b;
                m_op   <= pick(bus.req0_valid, bus.req1_valid, m_last) ? bus.req1_op : bus.req0_op;
                m_busy <= 1'b1;
                m_age  <= 1'b0;
            end
        end else if (!m_age) begin
            m_age <= 1'b1;
            {m_zero, m_res} <= alu_ref(m_op, m_a, m_b);
        end else if (m_id ? bus.rsp1_ready : bus.rsp0_ready) begin
            m_busy <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic g;
        g = pick(bus.req0_valid, bus.req1_valid, m_last);
        chk("busy",        bus.busy,       m_busy);
        chk("req0_ready",  bus.req0_ready, !reset && !m_busy && bus.req0_valid && !g);
        chk("req1_ready",  bus.req1_ready, !reset && !m_busy && bus.req1_valid && g);
        chk("rsp0_valid",  bus.rsp0_valid, m_busy && m_age && !m_id);
        chk("rsp1_valid",  bus.rsp1_valid, m_busy && m_age && m_id);
        chk("rsp0_result", bus.rsp0_result, m_res);
        chk("rsp1_result", bus.rsp1_result, m_res);
        chk("rsp0_zero",   bus.rsp0_zero,  m_zero);
        chk("rsp1_zero",   bus.rsp1_zero,  m_zero);
        chk("alu_input1",  bus.alu_input1, m_a);
        chk("alu_input2",  bus.alu_input2, m_b);
        chk("alu_ctrl",    bus.alu_ALUControl, m_op);
        if (bus.rsp0_valid && bus.rsp0_ready) rlog.push_back('{0, bus.rsp0_result, bus.rsp0_zero, cyc});
        if (bus.rsp1_valid && bus.rsp1_ready) rlog.push_back('{1, bus.rsp1_result, bus.rsp1_zero, cyc});
    end

    // Requester drivers: present queue head, pop on handshake.
    initial begin
        logic acc;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
        forever begin
            @(negedge clk);
            acc = bus.req0_valid && bus.req0_ready && !reset;
            if (acc) glog.push_back('{0, cyc});
            @(posedge clk); #2;
            if (acc) void'(q0.pop_front());
            if (q0.size() > 0) begin
                bus.req0_valid = 1'b1; bus.req0_a = q0[0].a; bus.req0_b = q0[0].b; bus.req0_op = q0[0].op;
            end else bus.req0_valid = 1'b0;
        end
    end

    initial begin
        logic acc;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
        forever begin
            @(negedge clk);
            acc = bus.req1_valid && bus.req1_ready && !reset;
            if (acc) glog.push_back('{1, cyc});
            @(posedge clk); #2;
            if (acc) void'(q1.pop_front());
            if (q1.size() > 0) begin
                bus.req1_valid = 1'b1; bus.req1_a = q1[0].a; bus.req1_b = q1[0].b; bus.req1_op = q1[0].op;
            end else bus.req1_valid = 1'b0;
        end
    end

    task automatic wait_rsp(input int n);
        int k = 0;
        do begin @(posedge clk); k++; end while (rlog.size() < n && k < 300);
        #1;
        chk("rsp_count", rlog.size(), n);
    endtask

    task automatic wait_grant(input int n);
        int k = 0;
        do begin @(posedge clk); k++; end while (glog.size() < n && k < 300);
        #1;
        chk("grant_count", glog.size(), n);
    endtask

    initial begin
        reset = 1'b0;
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;
        #1 reset = 1'b1;

        // Tie raised while reset is still high: no ready until release.
        q0.push_back('{32'd9, 32'd9, OP_SUB});
        q1.push_back('{32'h0000_00F0, 32'h0000_000F, OP_OR});
        @(negedge clk); @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_req0_ready", bus.req0_ready, 1'b0);
        chk("rst_alu_input1", bus.alu_input1, 32'd0);
        chk("rst_rsp0_valid", bus.rsp0_valid, 1'b0);
        @(posedge clk); #1 reset = 1'b0;

        wait_rsp(2);
        chk("tie_first_id",  glog[0].id, 0);
        chk("tie_second_id", glog[1].id, 1);
        chk("tie_r0_res",  rlog[0].res, 32'd0);
        chk("tie_r0_zero", rlog[0].z, 1'b1);
        chk("tie_r1_id",   rlog[1].id, 1);
        chk("tie_r1_res",  rlog[1].res, 32'h0000_00FF);
        chk("tie_r1_zero", rlog[1].z, 1'b0);

        q0.push_back('{32'd5, 32'd7, OP_ADD});
        wait_rsp(3);
        chk("add_id",   rlog[2].id, 0);
        chk("add_res",  rlog[2].res, 32'd12);
        chk("add_zero", rlog[2].z, 1'b0);
        chk("add_latency", rlog[2].cyc - glog[2].cyc, 2);

        q1.push_back('{32'h0000_FF00, 32'h0000_0FF0, OP_AND});
        q1.push_back('{32'd3, 32'd5, OP_SLT});
        q1.push_back('{32'd5, 32'd3, OP_SLT});
        q1.push_back('{32'd7, 32'd9, OP_BAD});
        wait_rsp(7);
        chk("and_res",   rlog[3].res, 32'h0000_0F00);
        chk("slt_t_res", rlog[4].res, 32'd1);
        chk("slt_f_res", rlog[5].res, 32'd0);
        chk("slt_f_zero", rlog[5].z, 1'b1);
        chk("bad_res",   rlog[6].res, 32'd0);
        chk("bad_zero",  rlog[6].z, 1'b1);

        // Backpressure on rsp0 while req1 waits.
        bus.rsp0_ready = 1'b0;
        q0.push_back('{32'h10, 32'h20, OP_ADD});
        wait_grant(8);
        q1.push_back('{32'd2, 32'd3, OP_ADD});
        begin
            int k = 0;
            do begin @(negedge clk); k++; end while (!bus.rsp0_valid && k < 20);
        end
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid",  bus.rsp0_valid, 1'b1);
            chk("bp_result", bus.rsp0_result, 32'h30);
            chk("bp_zero",   bus.rsp0_zero, 1'b0);
            chk("bp_req1_ready", bus.req1_ready, 1'b0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp0_ready = 1'b1;
        wait_rsp(9);
        chk("bp_next_id",  glog[8].id, 1);
        chk("bp_next_cyc", glog[8].cyc - rlog[7].cyc, 1);
        chk("bp_r1_res",   rlog[8].res, 32'd5);

        // Reset during EXEC of a req1 operation.
        q1.push_back('{32'd20, 32'd5, OP_SUB});
        wait_grant(10);
        chk("mid_busy_before", bus.busy, 1'b1);
        reset = 1'b1;
        #1;
        chk("mid_busy",   bus.busy, 1'b0);
        chk("mid_rsp1",   bus.rsp1_valid, 1'b0);
        chk("mid_alu_a",  bus.alu_input1, 32'd0);
        chk("mid_alu_op", bus.alu_ALUControl, 4'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        #1 chk("mid_no_rsp", rlog.size(), 9);
        q1.push_back('{32'd1, 32'd1, OP_ADD});
        wait_rsp(10);
        chk("post_id",  rlog[9].id, 1);
        chk("post_res", rlog[9].res, 32'd2);

        // Fairness with both continuously valid.
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{32'(i), 32'd10, OP_ADD});
            q1.push_back('{32'd100, 32'(i), OP_SUB});
        end
        wait_rsp(18);
        for (int j = 0; j < 8; j++) begin
            chk("fair_grant_id", glog[11 + j].id, j % 2);
            chk("fair_rsp_id",   rlog[10 + j].id, j % 2);
            chk("fair_rsp_res",  rlog[10 + j].res,
                (j % 2 == 0) ? 32'(j / 2 + 10) : 32'(100 - j / 2));
            if (j > 0) chk("fair_spacing", glog[11 + j].cyc - glog[10 + j].cyc, 3);
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester front end for the shared 32-bit ALU. It accepts operation requests (operands plus 4-bit ALU control code) from two independent clients over valid/ready handshakes. Requests are arbitrated round-robin, the winner's operands are latched and driven into the combinational ALU, and the registered result and zero flag are returned to the winner over a valid/ready response channel. The block sits between the multi-cycle control units that share one ALU instance and that ALU.

## Interface
- WIDTH, 32, operand/result width; must match the ALU.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid & ready).
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands.
- req0_op / req1_op  in  4  ALU control code.
- rsp0_valid / rsp1_valid  out  1  response present.
- rsp0_ready / rsp1_ready  in  1  response consumed.
- rsp0_result / rsp1_result  out  WIDTH  ALU result.
- rsp0_zero / rsp1_zero  out  1  ALU zero flag.
- busy  out  1  high whenever state ≠ IDLE.
- alu_input1, alu_input2  out  WIDTH  driven to the ALU operands.
- alu_ALUControl  out  4  driven to the ALU control.
- alu_result  in  WIDTH  from the ALU.
- alu_zero  in  1  from the ALU.

## Operation
- FSM: IDLE → EXEC → RESP → IDLE.
- IDLE arbitration:
  - Exactly one reqN_valid: grant N.
  - Both valid: grant the requester other than `last`. `last` resets to 1, so requester 0 wins the first tie.
  - reqN_ready is combinational: high only in IDLE for the granted requester.
- On accept:
  - Latch a, b, op and the granted id.
  - Set last <= id.
  - Go to EXEC.
- alu_input1/alu_input2/alu_ALUControl come only from the latched registers. They hold their last values in all states and never follow the req buses combinationally.
- EXEC (one cycle): capture alu_result and alu_zero into the result registers at the clock edge, then go to RESP.
- RESP:
  - rsp[id]_valid = 1; the other rsp valid = 0.
  - rsp[id]_result and rsp[id]_zero come from the result registers. The non-selected response outputs also show the registers, qualified by valid = 0.
  - When rsp[id]_ready = 1, go to IDLE.
- Op codes pass through unchecked. Unsupported codes yield whatever the ALU returns (result 0, zero 1).
- Requester rules: hold valid and payload stable until accepted. The block holds rsp payload stable while rsp valid is high and ready is low.
- While busy, a new request is never accepted, including one arriving in the same cycle a response completes. The earliest next accept is the cycle after the return to IDLE.

## Timing
- Reset (async, takes effect immediately):
  - State = IDLE, last = 1.
  - Latched a/b/op = 0, result = 0, zero = 0.
  - All rsp valid = 0, all req ready = 0 while reset is high, busy = 0.
  - alu_* outputs = 0.
- Latency:
  - Accept edge T.
  - EXEC occupies cycle T+1.
  - rsp valid is high from cycle T+2.
  - With rsp ready held high, IDLE is re-entered at T+3, giving a minimum of 3 cycles per operation.
- Reset during EXEC or RESP: the transaction is dropped and no response is ever produced for it. After release, the first request is arbitrated with last = 1.
- Response backpressure: stall indefinitely in RESP. The pending request on the other channel waits with ready = 0.
- Starvation bound: with both requesters continuously valid, grants strictly alternate.

## Test plan
- Single request: req0 ADD (op 0010), a=5, b=7 → req0_ready in the accept cycle; rsp0_valid two cycles later with result=12, zero=0; rsp1_valid stays 0.
- Tie after reset: req0 SUB (0110) 9−9 and req1 OR (0001) 0xF0|0x0F raised together → req0 served first (result 0, zero 1), then req1 (result 0xFF, zero 0).
- Backpressure: rsp0_ready held low 5 cycles with req1 valid → rsp0_valid, result and zero stable all 5 cycles; req1_ready stays 0; req1 accepted the cycle after return to IDLE.
- Op coverage: AND 0xFF00&0x0FF0 → 0x0F00; SLT 3<5 → 1; SLT 5<3 → 0 with zero=1; op 1111 → result 0, zero 1.
- Reset mid-op: assert reset during EXEC of req1 → busy, rsp valids and alu_* drop to 0 immediately; no rsp1 handshake occurs; a post-reset req1 ADD 1+1 returns 2.
- Fairness: both requesters valid for 4 requests each, rsp ready tied high → grant order 0,1,0,1,0,1,0,1; each response carries its own requester's result; 3 cycles per operation.
